n1_pbus_tgt: RTL and testbench
==============================

Name: n1_pbus_tgt

Overview:
Pipelined Wishbone target (responder) for the N1 program bus. It accepts fetch and data requests from the N1 flow-control initiator and issues them to a fixed-latency synchronous program memory. It returns in-order ACK/ERR/RTY responses and applies STALL backpressure. It is the memory-side counterpart of the pbus initiator and is used in SoC integration and in formal/simulation benches as the pbus model.

Parameters:
ADR_WIDTH, 16, pbus word address width
DAT_WIDTH, 16, pbus data width
MEM_LAT, 2, memory read latency in cycles (1..4); also the response latency
ADR_LIMIT, 16'hC000, first illegal word address; requests with adr >= ADR_LIMIT get ERR

Ports:
clk_i  in  1  module clock
sync_rst_i  in  1  synchronous reset, active-low
pbus_cyc_i  in  1  bus cycle indicator
pbus_stb_i  in  1  access request
pbus_we_i  in  1  write enable
pbus_adr_i  in  ADR_WIDTH  word address
pbus_dat_i  in  DAT_WIDTH  write data
pbus_dat_o  out  DAT_WIDTH  read data, valid with pbus_ack_o
pbus_ack_o  out  1  acknowledge
pbus_err_o  out  1  error response
pbus_rty_o  out  1  retry response
pbus_stall_o  out  1  access delay
mem_req_o  out  1  memory access strobe
mem_we_o  out  1  memory write
mem_adr_o  out  ADR_WIDTH  memory address
mem_dat_o  out  DAT_WIDTH  memory write data
mem_dat_i  in  DAT_WIDTH  memory read data, valid MEM_LAT cycles after mem_req_o
mem_busy_i  in  1  memory cannot accept a request this cycle
prb_pbus_tgt_state_o  out  2  FSM state
prb_pbus_tgt_pend_o  out  3  outstanding request count

Behaviour:
- Clock clk_i. Reset sync_rst_i is synchronous and active-low. While low at a clk_i edge: FSM=IDLE, tag pipeline cleared, pend=0. All response outputs read 0 in the cycle after reset is sampled low.
- Accept condition: pbus_cyc_i & pbus_stb_i & ~pbus_stall_i.
- Classification at accept (priority order):
  1. adr >= ADR_LIMIT gives ERR; no mem_req_o.
  2. Otherwise, if the RTY feature is enabled and mem_busy_i=1, gives RTY; no mem_req_o.
  3. Otherwise gives ACK, with mem_req_o=1, mem_we_o=pbus_we_i, and mem_adr_o/mem_dat_o passed through combinationally.
- Tag pipeline: MEM_LAT stages of {valid, kind[1:0]}, shifting every cycle. The stage-0 tag is written with the classification when a request is accepted, else written invalid.
- Responses: an accept in cycle N produces exactly one response in cycle N+MEM_LAT, with one-hot ack/err/rty. Responses are strictly in order and never backpressured.
- pbus_dat_o = mem_dat_i when ACK for a read, else 0. Writes return ACK with dat_o=0.
- pend = accepts minus responses, range 0..MEM_LAT.
  - Increments on accept only; decrements on response only; unchanged when both occur in the same cycle.
  - Saturation is unreachable by construction (fixed latency); this is checked by assertion.
- FSM states:
  - IDLE=0: cyc low, pend=0.
  - ACTIVE=1: cyc high.
  - DRAIN=2: cyc low with pend>0.
  - ABORT=3: one-cycle flush.
- FSM transitions:
  - IDLE to ACTIVE on cyc=1.
  - ACTIVE to IDLE on cyc=0 with pend=0.
  - ACTIVE to ABORT on cyc=0 with pend>0.
  - ABORT clears all valid tags and pend, then moves to IDLE, or to ACTIVE if cyc=1.
  - DRAIN is reserved, unreachable, and covered by an assertion.
- Abort rule: responses are suppressed from the cycle cyc falls. Memory writes already issued are not undone.
- pbus_stall_i (stall output) is asserted in ABORT and, when the RTY feature is disabled, whenever mem_busy_i=1 (combinational).
- Simultaneous accept and cyc fall cannot occur, because accept requires cyc.
- A request issued during the ABORT cycle is stalled.
- A mid-operation reset discards all outstanding tags; no late responses are produced after reset.

Optional Feature:
N1_PBUS_TGT_RTY_EN
- Defined: mem_busy_i does not stall. A request accepted while mem_busy_i=1 (and in range) is answered with pbus_rty_o after MEM_LAT cycles, and the initiator re-issues it.
- Undefined: pbus_rty_o is tied to 0, and mem_busy_i drives pbus_stall_o so the request is held on the bus until the memory is free.

Test Plan:
1. MEM_LAT=2, back-to-back reads at adr 0x0010, 0x0011, 0x0012 in cycles 5, 6, 7 with mem_dat_i=adr^16'hFFFF: ack in cycles 7, 8, 9 with dat_o 0xFFEF, 0xFFEE, 0xFFED; pend peaks at 2.
2. Read at 0xC000 followed by read at 0x0001: err in cycle N+2 and ack in N+3, in order; no mem_req_o issued for 0xC000.
3. Without RTY_EN, mem_busy_i=1 for 3 cycles while stb is high: stall_o high for 3 cycles, one mem_req_o after busy drops, one ack 2 cycles later.
4. With RTY_EN, same stimulus: first request gets rty in N+2; re-issue after busy drops gets ack.
5. Two reads accepted, then cyc dropped the next cycle: FSM passes through ABORT, no ack/err/rty seen, pend=0, state IDLE within 2 cycles.
6. sync_rst_i low for one cycle with 2 requests pending: all outputs 0 afterwards, no late ack; a new read then completes normally with 2-cycle latency.

Source files
------------

// File: rtl/n1_pbus_tgt.sv
// Pipelined Wishbone target for the N1 program bus, fronting a fixed-latency program memory.
// Build option: define N1_PBUS_TGT_RTY_EN to answer busy-memory requests with RTY instead of STALL.
module n1_pbus_tgt #(
    parameter int                   ADR_WIDTH = 16,
    parameter int                   DAT_WIDTH = 16,
    parameter int                   MEM_LAT   = 2,
    parameter logic [ADR_WIDTH-1:0] ADR_LIMIT = 16'hC000
) (
    input  logic                 clk_i,
    input  logic                 sync_rst_i,
    input  logic                 pbus_cyc_i,
    input  logic                 pbus_stb_i,
    input  logic                 pbus_we_i,
    input  logic [ADR_WIDTH-1:0] pbus_adr_i,
    input  logic [DAT_WIDTH-1:0] pbus_dat_i,
    output logic [DAT_WIDTH-1:0] pbus_dat_o,
    output logic                 pbus_ack_o,
    output logic                 pbus_err_o,
    output logic                 pbus_rty_o,
    output logic                 pbus_stall_o,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [ADR_WIDTH-1:0] mem_adr_o,
    output logic [DAT_WIDTH-1:0] mem_dat_o,
    input  logic [DAT_WIDTH-1:0] mem_dat_i,
    input  logic                 mem_busy_i,
    output logic [1:0]           prb_pbus_tgt_state_o,
    output logic [2:0]           prb_pbus_tgt_pend_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_ABORT  = 2'd3
    } state_t;

    localparam logic [1:0] K_RD  = 2'd0;
    localparam logic [1:0] K_WR  = 2'd1;
    localparam logic [1:0] K_ERR = 2'd2;
    localparam logic [1:0] K_RTY = 2'd3;

    state_t             state_q;
    logic [MEM_LAT-1:0] tag_v_q;
    logic [1:0]         tag_k_q [MEM_LAT];
    logic [2:0]         pend_q;
    logic [2:0]         pend_d;

    logic       in_range;
    logic       busy_rty;
    logic       accept;
    logic [1:0] kind_new;
    logic       rsp_live;
    logic [1:0] rsp_kind;
    logic       rsp_v;

    assign in_range = (pbus_adr_i < ADR_LIMIT);

`ifdef N1_PBUS_TGT_RTY_EN
    assign pbus_stall_o = (state_q == ST_ABORT);
    assign busy_rty     = mem_busy_i;
`else
    assign pbus_stall_o = (state_q == ST_ABORT) | mem_busy_i;
    assign busy_rty     = 1'b0;
`endif

    // Gated by reset so nothing reaches memory in a cycle whose tag would be discarded.
    assign accept = sync_rst_i & pbus_cyc_i & pbus_stb_i & ~pbus_stall_o;

    always_comb begin
        kind_new = K_RD;
        if (!in_range)      kind_new = K_ERR;
        else if (busy_rty)  kind_new = K_RTY;
        else if (pbus_we_i) kind_new = K_WR;
    end

    assign mem_req_o = accept & in_range & ~busy_rty;
    assign mem_we_o  = mem_req_o & pbus_we_i;
    assign mem_adr_o = pbus_adr_i;
    assign mem_dat_o = pbus_dat_i;

    // Responses die from the cycle cyc falls and through the flush cycle.
    assign rsp_live = tag_v_q[MEM_LAT-1];
    assign rsp_kind = tag_k_q[MEM_LAT-1];
    assign rsp_v    = rsp_live & pbus_cyc_i & (state_q != ST_ABORT);

    assign pbus_ack_o = rsp_v & ((rsp_kind == K_RD) | (rsp_kind == K_WR));
    assign pbus_err_o = rsp_v & (rsp_kind == K_ERR);
`ifdef N1_PBUS_TGT_RTY_EN
    assign pbus_rty_o = rsp_v & (rsp_kind == K_RTY);
`else
    assign pbus_rty_o = 1'b0;
`endif
    assign pbus_dat_o = (rsp_v && rsp_kind == K_RD) ? mem_dat_i : '0;

    assign pend_d = pend_q + {2'b00, accept} - {2'b00, rsp_live};

    always_ff @(posedge clk_i) begin
        if (!sync_rst_i) begin
            state_q <= ST_IDLE;
            tag_v_q <= '0;
            pend_q  <= '0;
        end else begin
            tag_v_q[0] <= accept;
            for (int i = 1; i < MEM_LAT; i++) begin
                tag_v_q[i] <= tag_v_q[i-1];
            end
            pend_q <= pend_d;
            case (state_q)
                ST_IDLE: begin
                    if (pbus_cyc_i) state_q <= ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (!pbus_cyc_i) state_q <= (pend_q == 3'd0) ? ST_IDLE : ST_ABORT;
                end
                ST_ABORT: begin
                    tag_v_q <= '0;
                    pend_q  <= '0;
                    state_q <= pbus_cyc_i ? ST_ACTIVE : ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Kind bits are meaningful only alongside a valid bit, so they need no reset.
    always_ff @(posedge clk_i) begin
        tag_k_q[0] <= kind_new;
        for (int i = 1; i < MEM_LAT; i++) begin
            tag_k_q[i] <= tag_k_q[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            assert (pend_q <= 3'(MEM_LAT));
            assert (state_q != ST_DRAIN);
        end
    end

    assign prb_pbus_tgt_state_o = state_q;
    assign prb_pbus_tgt_pend_o  = pend_q;

endmodule

// File: tb/tb_n1_pbus_tgt.sv
// Directed bench for n1_pbus_tgt (MEM_LAT=2); expectations follow the build's N1_PBUS_TGT_RTY_EN setting.
module tb_n1_pbus_tgt;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cyc, stb, we;
    logic [15:0] adr, wdat;
    logic [15:0] rdat;
    logic        ack, err, rty, stall;
    logic        mem_req, mem_we;
    logic [15:0] mem_adr, mem_wdat, mem_rdat;
    logic        mem_busy;
    logic [1:0]  state;
    logic [2:0]  pend;
    logic [15:0] mem_d1, mem_d2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    n1_pbus_tgt dut (
        .clk_i                (clk),
        .sync_rst_i           (rst_n),
        .pbus_cyc_i           (cyc),
        .pbus_stb_i           (stb),
        .pbus_we_i            (we),
        .pbus_adr_i           (adr),
        .pbus_dat_i           (wdat),
        .pbus_dat_o           (rdat),
        .pbus_ack_o           (ack),
        .pbus_err_o           (err),
        .pbus_rty_o           (rty),
        .pbus_stall_o         (stall),
        .mem_req_o            (mem_req),
        .mem_we_o             (mem_we),
        .mem_adr_o            (mem_adr),
        .mem_dat_o            (mem_wdat),
        .mem_dat_i            (mem_rdat),
        .mem_busy_i           (mem_busy),
        .prb_pbus_tgt_state_o (state),
        .prb_pbus_tgt_pend_o  (pend)
    );

    // Memory model: read data = adr ^ 16'hFFFF, two cycles after the request.
    always @(posedge clk) begin
        mem_d1 <= mem_req ? (mem_adr ^ 16'hFFFF) : 16'h0000;
        mem_d2 <= mem_d1;
    end
    assign mem_rdat = mem_d2;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic s, input logic w, input logic [15:0] a, input logic [15:0] d);
        stb  = s;
        we   = w;
        adr  = a;
        wdat = d;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        adr = '0; wdat = '0; mem_busy = 1'b0;
        tick(); tick();
        #1;
        chk("rst_rsp",   {ack, err, rty}, 3'b000);
        chk("rst_state", state, 2'd0);
        chk("rst_pend",  pend, 3'd0);
        chk("rst_stall", stall, 1'b0);
        rst_n = 1'b1;

        // back-to-back reads
        tick(); cyc = 1'b1; req(1, 0, 16'h0010, 0);
        chk("t1_req0", {mem_req, mem_we, mem_adr}, {2'b10, 16'h0010});
        tick(); req(1, 0, 16'h0011, 0);
        chk("t1_state", state, 2'd1);
        chk("t1_pend1", pend, 3'd1);
        chk("t1_rsp0",  {ack, err, rty}, 3'b000);
        tick(); req(1, 0, 16'h0012, 0);
        chk("t1_ack0",  {ack, err, rty, rdat}, {3'b100, 16'hFFEF});
        chk("t1_pend2", pend, 3'd2);
        tick(); req(0, 0, 16'h0000, 0);
        chk("t1_ack1",  {ack, err, rty, rdat}, {3'b100, 16'hFFEE});
        chk("t1_pendb", pend, 3'd2);
        tick();
        chk("t1_ack2",  {ack, err, rty, rdat}, {3'b100, 16'hFFED});
        chk("t1_pend3", pend, 3'd1);
        tick();
        chk("t1_idle",  {ack, err, rty, rdat}, {3'b000, 16'h0000});
        chk("t1_pend0", pend, 3'd0);

        // out-of-range then in-range
        tick(); req(1, 0, 16'hC000, 0);
        chk("t2_noreq", mem_req, 1'b0);
        tick(); req(1, 0, 16'h0001, 0);
        chk("t2_req",   mem_req, 1'b1);
        tick(); req(0, 0, 16'h0000, 0);
        chk("t2_err",   {ack, err, rty, rdat}, {3'b010, 16'h0000});
        tick();
        chk("t2_ack",   {ack, err, rty, rdat}, {3'b100, 16'hFFFE});

        // write returns ack with zero data
        tick(); req(1, 1, 16'h0030, 16'h1234);
        chk("t4_wr",    {mem_req, mem_we, mem_adr, mem_wdat}, {2'b11, 16'h0030, 16'h1234});
        tick(); req(0, 0, 16'h0000, 0);
        tick();
        chk("t4_wack",  {ack, err, rty, rdat}, {3'b100, 16'h0000});

        // busy memory: stall or retry depending on build
        tick(); mem_busy = 1'b1; req(1, 0, 16'h0020, 0);
        chk("t3_req_b0", mem_req, 1'b0);
`ifdef N1_PBUS_TGT_RTY_EN
        chk("t3_stall_b0", stall, 1'b0);
`else
        chk("t3_stall_b0", stall, 1'b1);
`endif
        tick();
        chk("t3_req_b1", mem_req, 1'b0);
        tick();
`ifdef N1_PBUS_TGT_RTY_EN
        chk("t3_rsp_b2", {ack, err, rty}, 3'b001);
`else
        chk("t3_rsp_b2", {ack, err, rty}, 3'b000);
        chk("t3_stall_b2", stall, 1'b1);
`endif
        tick(); mem_busy = 1'b0; #1;
        chk("t3_stall_b3", stall, 1'b0);
        chk("t3_req_b3",   {mem_req, mem_adr}, {1'b1, 16'h0020});
`ifdef N1_PBUS_TGT_RTY_EN
        chk("t3_rsp_b3", {ack, err, rty}, 3'b001);
`else
        chk("t3_rsp_b3", {ack, err, rty}, 3'b000);
`endif
        tick(); req(0, 0, 16'h0000, 0);
`ifdef N1_PBUS_TGT_RTY_EN
        chk("t3_rsp_b4", {ack, err, rty}, 3'b001);
`else
        chk("t3_rsp_b4", {ack, err, rty}, 3'b000);
`endif
        tick();
        chk("t3_ack",   {ack, err, rty, rdat}, {3'b100, 16'hFFDF});
        tick();
        chk("t3_pend0", pend, 3'd0);

        // abort with two reads outstanding
        tick(); req(1, 0, 16'h0040, 0);
        tick(); req(1, 0, 16'h0041, 0);
        tick(); cyc = 1'b0; req(0, 0, 16'h0000, 0);
        chk("t5_rsp_a2",   {ack, err, rty}, 3'b000);
        chk("t5_state_a2", state, 2'd1);
        tick();
        chk("t5_state_a3", state, 2'd3);
        chk("t5_rsp_a3",   {ack, err, rty}, 3'b000);
        chk("t5_stall_a3", stall, 1'b1);
        tick();
        chk("t5_state_a4", state, 2'd0);
        chk("t5_pend_a4",  pend, 3'd0);
        chk("t5_rsp_a4",   {ack, err, rty}, 3'b000);

        // reset with two requests pending
        tick(); cyc = 1'b1; req(1, 0, 16'h0050, 0);
        tick(); req(1, 0, 16'h0051, 0);
        tick(); rst_n = 1'b0; req(0, 0, 16'h0000, 0);
        tick(); rst_n = 1'b1; #1;
        chk("t6_rsp_r3",   {ack, err, rty, rdat}, {3'b000, 16'h0000});
        chk("t6_state_r3", state, 2'd0);
        chk("t6_pend_r3",  pend, 3'd0);
        req(1, 0, 16'h0060, 0);
        tick(); req(0, 0, 16'h0000, 0);
        chk("t6_rsp_r4",   {ack, err, rty}, 3'b000);
        chk("t6_state_r4", state, 2'd1);
        tick();
        chk("t6_ack",      {ack, err, rty, rdat}, {3'b100, 16'hFF9F});
        tick(); cyc = 1'b0;
        tick();
        chk("t6_end_state", state, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
